// File: rtl/intel8254_pkg.sv
// Shared 8254 definitions: bus/count widths, read/write mode encodings,
// status byte layout and the read-source type used by the readback path.
package intel8254_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COUNT_W = 16;

  // Control-word RW field encodings
  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_WORD  = 2'b11;

  // Status byte bit positions
  localparam int unsigned ST_OUT     = 7;
  localparam int unsigned ST_NULL    = 6;
  localparam int unsigned ST_RW_HI   = 5;
  localparam int unsigned ST_RW_LO   = 4;
  localparam int unsigned ST_MODE_HI = 3;
  localparam int unsigned ST_MODE_LO = 1;
  localparam int unsigned ST_BCD     = 0;

  // Where the byte of a read comes from
  typedef enum logic [1:0] {
    SrcNone,
    SrcStatus,
    SrcLatch,
    SrcLive
  } src_e;

  function automatic logic [BYTE_W-1:0] pack_status(input logic       out_pin,
                                                    input logic       null_count,
                                                    input logic [1:0] rw_mode,
                                                    input logic [2:0] mode,
                                                    input logic       bcd);
    logic [BYTE_W-1:0] s;
    s                        = '0;
    s[ST_OUT]                = out_pin;
    s[ST_NULL]               = null_count;
    s[ST_RW_HI:ST_RW_LO]     = rw_mode;
    s[ST_MODE_HI:ST_MODE_LO] = mode;
    s[ST_BCD]                = bcd;
    return s;
  endfunction

endpackage

// File: rtl/counter_readback_if.sv
// Bus between the CPU-side control/decode logic (master) and the counter
// readback datapath (slave). Carries read/command strobes, the control-word
// fields, the live counter state and the returned read data.
interface counter_readback_if;
  import intel8254_pkg::*;

  logic               cs;
  logic               rd;
  logic               latch_cmd;
  logic               status_cmd;
  logic               new_mode;
  logic [1:0]         rw_mode;
  logic [2:0]         mode;
  logic               bcd;
  logic [COUNT_W-1:0] current_count;
  logic               out_pin;
  logic               null_count;
  logic [BYTE_W-1:0]  data_out;
  logic               data_valid;

  modport master (
    output cs, rd, latch_cmd, status_cmd, new_mode, rw_mode, mode, bcd,
    output current_count, out_pin, null_count,
    input  data_out, data_valid
  );

  modport slave (
    input  cs, rd, latch_cmd, status_cmd, new_mode, rw_mode, mode, bcd,
    input  current_count, out_pin, null_count,
    output data_out, data_valid
  );

endinterface

// File: rtl/readback_byte_mux.sv
// Combinational source and byte selection for one counter read.
// Ports:
//   st_full, st   - status latch flag and byte
//   ol_full, ol   - count latch flag and value
//   rff           - read flip-flop (0 = next byte LSB)
//   rw_mode       - RW field of the current control word
//   live          - live count from the mode counter
//   byte_sel      - selected byte (zero when rw_mode is 00)
//   src           - which source the byte came from
//   msb           - the selected count byte is the MSB
module readback_byte_mux
  import intel8254_pkg::*;
(
  input  logic               st_full,
  input  logic [BYTE_W-1:0]  st,
  input  logic               ol_full,
  input  logic [COUNT_W-1:0] ol,
  input  logic               rff,
  input  logic [1:0]         rw_mode,
  input  logic [COUNT_W-1:0] live,
  output logic [BYTE_W-1:0]  byte_sel,
  output src_e               src,
  output logic               msb
);

  logic [COUNT_W-1:0] word;

  always_comb begin
    byte_sel = '0;
    src      = SrcNone;
    msb      = 1'b0;
    word     = ol_full ? ol : live;
    if (rw_mode == RW_LATCH) begin
      // Not a readable configuration: return zero, touch nothing
      src = SrcNone;
    end else if (st_full) begin
      src      = SrcStatus;
      byte_sel = st;
    end else begin
      src      = ol_full ? SrcLatch : SrcLive;
      msb      = (rw_mode == RW_MSB) || ((rw_mode == RW_WORD) && rff);
      byte_sel = msb ? word[COUNT_W-1:BYTE_W] : word[BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/counter_readback.sv
// Read-side datapath for one 8254 counter: counter latch, status latch and
// LSB/MSB read flip-flop. Returns one byte per read strobe, registered.
// Never modifies the counter's count.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave side of counter_readback_if (strobes, control fields,
//              live count/OUT/null-count in; data_out/data_valid out)
module counter_readback
  import intel8254_pkg::*;
(
  input logic               clk,
  input logic               rst,
  counter_readback_if.slave bus
);

  logic [COUNT_W-1:0] ol_q, ol_d;
  logic               ol_full_q, ol_full_d;
  logic [BYTE_W-1:0]  st_q, st_d;
  logic               st_full_q, st_full_d;
  logic               rff_q, rff_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               valid_q;

  logic              rd_en;
  logic [BYTE_W-1:0] byte_sel;
  src_e              src;
  logic              msb;
  logic              ol_full_rd, st_full_rd;

  assign rd_en = bus.cs & bus.rd;

  readback_byte_mux u_mux (
    .st_full  (st_full_q),
    .st       (st_q),
    .ol_full  (ol_full_q),
    .ol       (ol_q),
    .rff      (rff_q),
    .rw_mode  (bus.rw_mode),
    .live     (bus.current_count),
    .byte_sel (byte_sel),
    .src      (src),
    .msb      (msb)
  );

  always_comb begin
    // Effect of the read alone, from pre-edge state
    ol_full_rd = ol_full_q;
    st_full_rd = st_full_q;
    rff_d      = rff_q;
    data_d     = data_q;
    if (rd_en) begin
      data_d = byte_sel;
      case (src)
        SrcStatus: st_full_rd = 1'b0;
        SrcLatch: begin
          // Latch is done once its last byte is out
          if (bus.rw_mode != RW_WORD || msb) ol_full_rd = 1'b0;
          if (bus.rw_mode == RW_WORD) rff_d = ~rff_q;
        end
        SrcLive: begin
          if (bus.rw_mode == RW_WORD) rff_d = ~rff_q;
        end
        default: ;
      endcase
    end

    // Latch commands see the post-read flags, so a completing read frees
    // the latch for a capture at the same edge.
    ol_d      = ol_q;
    ol_full_d = ol_full_rd;
    st_d      = st_q;
    st_full_d = st_full_rd;
    if (bus.new_mode) begin
      ol_full_d = 1'b0;
      st_full_d = 1'b0;
      rff_d     = 1'b0;
    end else begin
      if (bus.cs && bus.latch_cmd && !ol_full_rd) begin
        ol_d      = bus.current_count;
        ol_full_d = 1'b1;
      end
      if (bus.cs && bus.status_cmd && !st_full_rd) begin
        st_d      = pack_status(bus.out_pin, bus.null_count, bus.rw_mode, bus.mode, bus.bcd);
        st_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ol_q      <= '0;
      ol_full_q <= 1'b0;
      st_q      <= '0;
      st_full_q <= 1'b0;
      rff_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      ol_q      <= ol_d;
      ol_full_q <= ol_full_d;
      st_q      <= st_d;
      st_full_q <= st_full_d;
      rff_q     <= rff_d;
      data_q    <= data_d;
      valid_q   <= rd_en;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;

endmodule

// File: tb/tb_counter_readback.sv
module tb_counter_readback;
  import intel8254_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_readback_if bus ();

  counter_readback dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  sb_q[$];
  string       tag_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest expected byte
  always @(negedge clk) begin
    if (!rst && bus.data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 16'(bus.data_out), 16'hxxxx);
      end else begin
        check(tag_q.pop_front(), 16'(bus.data_out), 16'(sb_q.pop_front()));
      end
    end
  end

  // One cycle of stimulus; drive at negedge, strobes cleared at the next negedge
  task automatic step(input logic r, input logic l, input logic s, input logic nm,
                      input logic [7:0] exp, input string tag);
    bus.rd         = r;
    bus.latch_cmd  = l;
    bus.status_cmd = s;
    bus.new_mode   = nm;
    if (r && bus.cs) begin
      sb_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(negedge clk);
    bus.rd         = 1'b0;
    bus.latch_cmd  = 1'b0;
    bus.status_cmd = 1'b0;
    bus.new_mode   = 1'b0;
  endtask

  task automatic rd_exp(input logic [7:0] exp, input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, exp, tag);
  endtask

  task automatic latch();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "");
  endtask

  initial begin
    bus.cs = 1'b1;  bus.rd = 1'b0;  bus.latch_cmd = 1'b0;  bus.status_cmd = 1'b0;
    bus.new_mode = 1'b0;  bus.rw_mode = RW_WORD;  bus.mode = 3'b000;  bus.bcd = 1'b0;
    bus.current_count = 16'h0000;  bus.out_pin = 1'b0;  bus.null_count = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("reset_data", 16'(bus.data_out), 16'h0000);
    check("reset_valid", 16'(bus.data_valid), 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-read
    bus.current_count = 16'hABCD;
    latch();
    rd_exp(8'hCD, "midread_lsb");
    #2 rst = 1'b1;
    #1;
    check("rst_data", 16'(bus.data_out), 16'h0000);
    check("rst_valid", 16'(bus.data_valid), 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    bus.current_count = 16'h1234;
    rd_exp(8'h34, "post_rst_lsb");
    rd_exp(8'h12, "post_rst_msb");

    // Latch hold: second latch ignored until first fully read
    bus.current_count = 16'h1234;
    latch();
    bus.current_count = 16'h0FFF;
    latch();
    rd_exp(8'h34, "hold_lsb");
    rd_exp(8'h12, "hold_msb");
    rd_exp(8'hFF, "hold_live_lsb");
    rd_exp(8'h0F, "hold_live_msb");

    // Status and count latched together
    bus.mode = 3'b001;  bus.bcd = 1'b0;  bus.out_pin = 1'b1;  bus.null_count = 1'b0;
    bus.current_count = 16'h00A5;
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "");
    bus.current_count = 16'h7E7E;
    rd_exp(8'b1011_0010, "status_byte");
    rd_exp(8'hA5, "status_then_lsb");
    rd_exp(8'h00, "status_then_msb");

    // Byte modes
    bus.rw_mode = RW_MSB;
    bus.current_count = 16'h5A3C;
    latch();
    bus.current_count = 16'h7766;
    rd_exp(8'h5A, "msb_only_latched");
    rd_exp(8'h77, "msb_only_live");
    bus.rw_mode = RW_LSB;
    bus.current_count = 16'h5A3C;
    rd_exp(8'h3C, "lsb_only_1");
    rd_exp(8'h3C, "lsb_only_2");
    bus.rw_mode = RW_WORD;
    rd_exp(8'h3C, "rff_untouched_lsb");
    rd_exp(8'h5A, "rff_untouched_msb");

    // Read and latch at the same edge
    bus.rw_mode = RW_LSB;
    bus.current_count = 16'h1111;
    latch();
    bus.current_count = 16'h2222;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, "rd_latch_old");
    bus.current_count = 16'h3333;
    rd_exp(8'h22, "rd_latch_new");

    // new_mode resets rff and blocks a simultaneous latch
    bus.rw_mode = RW_WORD;
    bus.current_count = 16'hBEEF;
    rd_exp(8'hEF, "nm_first_lsb");
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, "");
    rd_exp(8'hEF, "nm_lsb_again");
    bus.current_count = 16'h1234;
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "");
    bus.current_count = 16'h5678;
    rd_exp(8'h78, "nm_no_latch");

    // cs low: no data_valid, data_out holds, latch ignored
    bus.cs = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "");
    check("cs_low_valid", 16'(bus.data_valid), 16'h0000);
    check("cs_low_hold", 16'(bus.data_out), 16'h0078);
    bus.cs = 1'b1;
    bus.current_count = 16'h9ABC;
    rd_exp(8'h9A, "cs_low_rff_kept");

    // rw 00 returns zero with a valid pulse, no state change
    bus.rw_mode = RW_LATCH;
    rd_exp(8'h00, "rw00_zero");
    bus.rw_mode = RW_WORD;
    rd_exp(8'hBC, "rw00_no_state");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 16'(sb_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
